spart_mmio_bridge: RTL and testbench
====================================

SPART_MMIO_BRIDGE -- requirements
Module: spart_mmio_bridge

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, meaning entries per RX and TX byte FIFO; power of two, 2..64.
REQ-002 SHALL have parameter DATA_ADDR, default 28'h8000000, meaning the RX-pop/TX-push data register address.
REQ-003 SHALL have parameter STATUS_ADDR, default 28'h8000001, meaning the status register address.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 mem_data_wr1  input  32  write data from requester; bits [7:0] used.
REQ-007 mem_data_rd1  output  32  registered read data to requester.
REQ-008 mem_data_addr1  input  28  request address.
REQ-009 mem_rw_data1  input  1  1 = write, 0 = read.
REQ-010 mem_valid_data1  input  1  request valid; held with addr/rw/wdata until ready seen.
REQ-011 mem_ready_data1  output  1  one-cycle response strobe.
REQ-012 rx_byte  input  8  received byte from SPART core.
REQ-013 rx_strobe  input  1  one-cycle pulse; rx_byte valid.
REQ-014 tx_byte  output  8  byte to transmit; valid while tx_start high.
REQ-015 tx_start  output  1  one-cycle transmit pulse to SPART core.
REQ-016 tx_busy  input  1  SPART transmitter busy.

Function
REQ-017 Bus FSM SHALL have states IDLE, RESP, RELEASE.
REQ-018 IDLE with mem_valid_data1=1: perform access, latch mem_data_rd1, go to RESP.
REQ-019 RESP: mem_ready_data1=1 for exactly that one cycle; next state RELEASE unconditionally.
REQ-020 RELEASE: mem_ready_data1=0; go to IDLE only when mem_valid_data1=0; no new access accepted until then (no double-processing of a held request).
REQ-021 Latency: valid sampled high at edge N -> ready high in cycle after edge N, low after edge N+1.
REQ-022 Read DATA_ADDR, RX non-empty: mem_data_rd1={24'b0, RX head}, pop one entry.
REQ-023 Read DATA_ADDR, RX empty: mem_data_rd1=0, no pop, no error flag.
REQ-024 Read STATUS_ADDR: bit0=TX not full, bit1=RX not empty, bit2=rx_overflow, bit3=tx_drop, bits[31:4]=0; then clear bits 2 and 3 (set events in same cycle win).
REQ-025 Write DATA_ADDR, TX not full: push mem_data_wr1[7:0].
REQ-026 Write DATA_ADDR, TX full: discard byte, set sticky tx_drop.
REQ-027 Write STATUS_ADDR: ignored.
REQ-028 Any unmapped address: read returns 0, write ignored, ready still issued (no hang).
REQ-029 mem_data_rd1 SHALL hold last value until next read response; writes SHALL leave it unchanged.
REQ-030 rx_strobe with RX not full: push rx_byte; RX full: drop byte, set sticky rx_overflow.
REQ-031 Simultaneous push and pop on one FIFO SHALL both occur; occupancy unchanged; allowed when full (pop first) and legal when empty only for push.
REQ-032 FIFO pointers SHALL wrap modulo FIFO_DEPTH; occupancy counter width log2(FIFO_DEPTH)+1.
REQ-033 TX drain: TX non-empty, tx_busy=0, no tx_start in previous cycle -> tx_start=1 one cycle, tx_byte=head, pop.
REQ-034 tx_busy SHALL be ignored the cycle after tx_start (core busy-rise latency); minimum two cycles between tx_start pulses.
REQ-035 Bus TX push and drain pop in same cycle SHALL both occur.

Reset
REQ-036 rst=1 SHALL immediately force: FSM IDLE, both FIFOs empty, pointers 0, flags 0, mem_data_rd1=0, mem_ready_data1=0, tx_start=0, tx_byte=0.
REQ-037 Reset mid-transaction SHALL abandon it; after release the held request SHALL be treated as new in IDLE.
REQ-038 FIFO storage contents need not be reset.

Verification
REQ-039 Status poll after reset: read 0x8000001 -> ready one cycle after valid, rd=32'h1; hold valid 5 cycles -> exactly one ready pulse.
REQ-040 RX path: strobe 0x41,0x42; read status -> 32'h3; read data twice -> 32'h41, 32'h42; third read -> 0, status -> 32'h1.
REQ-041 RX overflow: FIFO_DEPTH=8, strobe 9 bytes -> status 32'h7; second status read -> 32'h3; 8 data reads return first 8 bytes in order.
REQ-042 TX path, tx_busy tied 0: write 0x55,0xAA -> tx_start pulses with tx_byte 0x55 then 0xAA, >=2 cycles apart.
REQ-043 TX full: tx_busy=1, write 9 bytes -> status 32'h8 (bit0=0); release tx_busy -> 8 bytes transmitted in order, status then 32'h1.
REQ-044 Reset mid-RESP with RX holding 3 bytes -> ready, tx_start low immediately; post-reset status -> 32'h1.

Source files
------------

// File: rtl/spart_mmio_bridge_if.sv
// Memory-mapped request/response bus between a requester and the SPART bridge.
// The requester holds valid/addr/rw/wdata until it sees the one-cycle ready strobe.
interface spart_mmio_bridge_if;
  logic [31:0] mem_data_wr1;
  logic [31:0] mem_data_rd1;
  logic [27:0] mem_data_addr1;
  logic        mem_rw_data1;
  logic        mem_valid_data1;
  logic        mem_ready_data1;

  modport master (
    output mem_data_wr1, mem_data_addr1, mem_rw_data1, mem_valid_data1,
    input  mem_data_rd1, mem_ready_data1
  );

  modport slave (
    input  mem_data_wr1, mem_data_addr1, mem_rw_data1, mem_valid_data1,
    output mem_data_rd1, mem_ready_data1
  );
endinterface

// File: rtl/spart_mmio_bridge.sv
// MMIO bridge between a held-request bus and a SPART byte core: RX/TX byte FIFOs,
// data/status registers, one ready pulse per request, TX drain paced against tx_busy.
module spart_mmio_bridge #(
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [27:0] DATA_ADDR   = 28'h8000000,
  parameter logic [27:0] STATUS_ADDR = 28'h8000001
) (
  input  logic                      clk,
  input  logic                      rst,
  spart_mmio_bridge_if.slave        bus,
  input  logic [7:0]                rx_byte,
  input  logic                      rx_strobe,
  output logic [7:0]                tx_byte,
  output logic                      tx_start,
  input  logic                      tx_busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RESP, RELEASE} state_t;
  state_t state_q, state_d;

  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [AW-1:0] rx_wr_ptr, rx_rd_ptr, tx_wr_ptr, tx_rd_ptr;
  logic [CW-1:0] rx_count, tx_count;
  logic          rx_overflow, tx_drop, tx_start_prev;
  logic [31:0]   rd_data;
  logic          accept, sel_data, sel_status;
  logic          rx_push, rx_pop, tx_wr, tx_push, tx_pop, stat_rd;
  logic          rx_nonempty, tx_notfull;
  logic          unused_wdata;

  assign unused_wdata = ^bus.mem_data_wr1[31:8];

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.mem_valid_data1) begin
          accept  = 1'b1;
          state_d = RESP;
        end
      end
      RESP:    state_d = RELEASE;
      // A request still held after its response must not be processed twice.
      RELEASE: if (!bus.mem_valid_data1) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.mem_ready_data1 = (state_q == RESP);

  assign sel_data    = (bus.mem_data_addr1 == DATA_ADDR);
  assign sel_status  = (bus.mem_data_addr1 == STATUS_ADDR);
  assign rx_nonempty = (rx_count != '0);
  assign tx_notfull  = (tx_count != FULL);

  assign rx_pop  = accept && !bus.mem_rw_data1 && sel_data && rx_nonempty;
  assign stat_rd = accept && !bus.mem_rw_data1 && sel_status;
  assign tx_wr   = accept && bus.mem_rw_data1 && sel_data;
  // The core's busy flag lags tx_start, so it is only trusted two cycles after a pulse.
  assign tx_pop  = (tx_count != '0) && !tx_busy && !tx_start && !tx_start_prev;
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign rx_push = rx_strobe && ((rx_count != FULL) || rx_pop);
  assign tx_push = tx_wr && (tx_notfull || tx_pop);

  always_comb begin
    rd_data = '0;
    if (sel_data && rx_nonempty)
      rd_data = {24'b0, rx_mem[rx_rd_ptr]};
    else if (sel_status)
      rd_data = {28'b0, tx_drop, rx_overflow, rx_nonempty, tx_notfull};
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_ptr] <= rx_byte;
    if (tx_push) tx_mem[tx_wr_ptr] <= bus.mem_data_wr1[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= IDLE;
      rx_wr_ptr        <= '0;
      rx_rd_ptr        <= '0;
      tx_wr_ptr        <= '0;
      tx_rd_ptr        <= '0;
      rx_count         <= '0;
      tx_count         <= '0;
      rx_overflow      <= 1'b0;
      tx_drop          <= 1'b0;
      bus.mem_data_rd1 <= '0;
      tx_start         <= 1'b0;
      tx_start_prev    <= 1'b0;
      tx_byte          <= '0;
    end else begin
      state_q <= state_d;
      if (accept && !bus.mem_rw_data1) bus.mem_data_rd1 <= rd_data;

      if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
      rx_count <= rx_count + CW'(rx_push) - CW'(rx_pop);

      if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
      tx_count <= tx_count + CW'(tx_push) - CW'(tx_pop);

      // Sticky flags clear on a status read, but a same-cycle event wins.
      rx_overflow <= (rx_strobe && !rx_push) || (rx_overflow && !stat_rd);
      tx_drop     <= (tx_wr && !tx_push) || (tx_drop && !stat_rd);

      tx_start      <= tx_pop;
      tx_start_prev <= tx_start;
      if (tx_pop) tx_byte <= tx_mem[tx_rd_ptr];
    end
  end
endmodule

// File: tb/tb_spart_mmio_bridge.sv
// Self-checking bench for spart_mmio_bridge: directed scenarios plus a randomized
// mix of bus and RX traffic checked against a queue-based reference model.
module tb_spart_mmio_bridge;
  localparam int          DEPTH = 8;
  localparam logic [27:0] DA    = 28'h8000000;
  localparam logic [27:0] SA    = 28'h8000001;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_byte;
  logic       rx_strobe;
  logic [7:0] tx_byte;
  logic       tx_start;
  logic       tx_busy;

  spart_mmio_bridge_if bus();

  spart_mmio_bridge #(
    .FIFO_DEPTH(DEPTH), .DATA_ADDR(DA), .STATUS_ADDR(SA)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .rx_byte(rx_byte), .rx_strobe(rx_strobe),
    .tx_byte(tx_byte), .tx_start(tx_start), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] tx_seen[$];
  int         tx_cyc[$];
  always @(negedge clk) begin
    if (tx_start === 1'b1) begin
      tx_seen.push_back(tx_byte);
      tx_cyc.push_back(cyc);
    end
  end

  // Reference model state
  logic [7:0]  m_rx[$];
  bit          m_ovf, m_drop;
  logic [31:0] m_last;
  logic [7:0]  tx_exp[$];

  initial begin
    #3_000_000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

  task automatic access(input bit rw, input logic [27:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output int lat);
    @(negedge clk);
    bus.mem_rw_data1    = rw;
    bus.mem_data_addr1  = addr;
    bus.mem_data_wr1    = wd;
    bus.mem_valid_data1 = 1'b1;
    lat = 0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (bus.mem_ready_data1 === 1'b1) begin
        lat = i;
        break;
      end
    end
    rd = bus.mem_data_rd1;
    @(negedge clk);
    bus.mem_valid_data1 = 1'b0;
    @(posedge clk);
    @(posedge clk);
  endtask

  task automatic strobe(input logic [7:0] b);
    @(negedge clk);
    rx_byte   = b;
    rx_strobe = 1'b1;
    @(negedge clk);
    rx_strobe = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] rd;
    int lat, pulses;
    rst = 1'b1; rx_strobe = 1'b0; rx_byte = '0; tx_busy = 1'b0;
    bus.mem_valid_data1 = 1'b0; bus.mem_rw_data1 = 1'b0;
    bus.mem_data_addr1 = '0; bus.mem_data_wr1 = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.mem_ready_data1 !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", bus.mem_ready_data1); end
    checks++; if (tx_start !== 1'b0) begin failures++; $display("FAIL reset_tx_start got=%b exp=0", tx_start); end
    checks++; if (tx_byte !== 8'h00) begin failures++; $display("FAIL reset_tx_byte got=%h exp=00", tx_byte); end
    checks++; if (bus.mem_data_rd1 !== 32'h0) begin failures++; $display("FAIL reset_rd got=%h exp=0", bus.mem_data_rd1); end
    @(negedge clk); rst = 1'b0;
    access(1'b0, SA, 32'h0, rd, lat);
    checks++; if (rd !== 32'h1) begin failures++; $display("FAIL status_after_reset got=%h exp=1", rd); end
    checks++; if (lat !== 1) begin failures++; $display("FAIL ready_latency got=%0d exp=1", lat); end
    // Held request: exactly one ready pulse over five cycles.
    @(negedge clk);
    bus.mem_rw_data1 = 1'b0; bus.mem_data_addr1 = SA; bus.mem_valid_data1 = 1'b1;
    pulses = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (bus.mem_ready_data1 === 1'b1) pulses++;
    end
    checks++; if (pulses !== 1) begin failures++; $display("FAIL held_valid_pulses got=%0d exp=1", pulses); end
    checks++; if (bus.mem_data_rd1 !== 32'h1) begin failures++; $display("FAIL held_valid_rd got=%h exp=1", bus.mem_data_rd1); end
    @(negedge clk); bus.mem_valid_data1 = 1'b0;
    @(posedge clk); @(posedge clk);
  endtask

  task automatic test_rx_path;
    logic [31:0] rd;
    int lat;
    strobe(8'h41);
    strobe(8'h42);
    access(1'b0, SA, 0, rd, lat);
    checks++; if (rd !== 32'h3) begin failures++; $display("FAIL rx_status got=%h exp=3", rd); end
    access(1'b0, DA, 0, rd, lat);
    checks++; if (rd !== 32'h41) begin failures++; $display("FAIL rx_data0 got=%h exp=41", rd); end
    access(1'b0, DA, 0, rd, lat);
    checks++; if (rd !== 32'h42) begin failures++; $display("FAIL rx_data1 got=%h exp=42", rd); end
    access(1'b0, DA, 0, rd, lat);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL rx_empty_read got=%h exp=0", rd); end
    access(1'b0, SA, 0, rd, lat);
    checks++; if (rd !== 32'h1) begin failures++; $display("FAIL rx_status_empty got=%h exp=1", rd); end
  endtask

  task automatic test_rx_overflow;
    logic [31:0] rd;
    logic [7:0] b[9];
    int lat;
    for (int i = 0; i < 9; i++) begin
      b[i] = 8'($urandom);
      strobe(b[i]);
    end
    access(1'b0, SA, 0, rd, lat);
    checks++; if (rd !== 32'h7) begin failures++; $display("FAIL ovf_status got=%h exp=7", rd); end
    access(1'b0, SA, 0, rd, lat);
    checks++; if (rd !== 32'h3) begin failures++; $display("FAIL ovf_status_cleared got=%h exp=3", rd); end
    for (int i = 0; i < 8; i++) begin
      access(1'b0, DA, 0, rd, lat);
      checks++; if (rd !== {24'b0, b[i]}) begin failures++; $display("FAIL ovf_data[%0d] got=%h exp=%h", i, rd, b[i]); end
    end
    access(1'b0, SA, 0, rd, lat);
    checks++; if (rd !== 32'h1) begin failures++; $display("FAIL ovf_status_drained got=%h exp=1", rd); end
  endtask

  task automatic test_tx_path;
    logic [31:0] rd;
    int lat;
    tx_busy = 1'b0;
    tx_seen.delete(); tx_cyc.delete();
    access(1'b1, DA, 32'h55, rd, lat);
    access(1'b1, DA, 32'hAA, rd, lat);
    repeat (20) @(posedge clk);
    checks++; if (tx_seen.size() !== 2) begin failures++; $display("FAIL tx_count got=%0d exp=2", tx_seen.size()); end
    if (tx_seen.size() == 2) begin
      checks++; if (tx_seen[0] !== 8'h55) begin failures++; $display("FAIL tx_byte0 got=%h exp=55", tx_seen[0]); end
      checks++; if (tx_seen[1] !== 8'hAA) begin failures++; $display("FAIL tx_byte1 got=%h exp=aa", tx_seen[1]); end
      checks++; if (tx_cyc[1] - tx_cyc[0] < 2) begin failures++; $display("FAIL tx_gap got=%0d exp>=2", tx_cyc[1] - tx_cyc[0]); end
    end
  endtask

  task automatic test_tx_full;
    logic [31:0] rd;
    logic [7:0] b[9];
    int lat;
    tx_busy = 1'b1;
    tx_seen.delete(); tx_cyc.delete();
    for (int i = 0; i < 9; i++) begin
      b[i] = 8'($urandom);
      access(1'b1, DA, {24'hABCDEF, b[i]}, rd, lat);
    end
    access(1'b0, SA, 0, rd, lat);
    checks++; if (rd !== 32'h8) begin failures++; $display("FAIL txfull_status got=%h exp=8", rd); end
    checks++; if (tx_seen.size() !== 0) begin failures++; $display("FAIL txfull_sent_while_busy got=%0d exp=0", tx_seen.size()); end
    tx_busy = 1'b0;
    repeat (60) @(posedge clk);
    checks++; if (tx_seen.size() !== 8) begin failures++; $display("FAIL txfull_count got=%0d exp=8", tx_seen.size()); end
    for (int i = 0; i < 8 && i < tx_seen.size(); i++) begin
      checks++; if (tx_seen[i] !== b[i]) begin failures++; $display("FAIL txfull_byte[%0d] got=%h exp=%h", i, tx_seen[i], b[i]); end
    end
    for (int i = 1; i < tx_cyc.size(); i++) begin
      checks++; if (tx_cyc[i] - tx_cyc[i-1] < 2) begin failures++; $display("FAIL txfull_gap[%0d] got=%0d exp>=2", i, tx_cyc[i] - tx_cyc[i-1]); end
    end
    access(1'b0, SA, 0, rd, lat);
    checks++; if (rd !== 32'h1) begin failures++; $display("FAIL txfull_status_after got=%h exp=1", rd); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd;
    int lat;
    bit seen;
    strobe(8'h11); strobe(8'h22); strobe(8'h33);
    @(negedge clk);
    bus.mem_rw_data1 = 1'b0; bus.mem_data_addr1 = SA; bus.mem_valid_data1 = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus.mem_ready_data1 === 1'b1) begin seen = 1'b1; break; end
    end
    checks++; if (!seen) begin failures++; $display("FAIL midreset_no_ready got=0 exp=1"); end
    rst = 1'b1;
    #1;
    checks++; if (bus.mem_ready_data1 !== 1'b0) begin failures++; $display("FAIL midreset_ready got=%b exp=0", bus.mem_ready_data1); end
    checks++; if (tx_start !== 1'b0) begin failures++; $display("FAIL midreset_tx_start got=%b exp=0", tx_start); end
    checks++; if (bus.mem_data_rd1 !== 32'h0) begin failures++; $display("FAIL midreset_rd got=%h exp=0", bus.mem_data_rd1); end
    // Request stays held across reset and is served again as a fresh one.
    @(negedge clk); rst = 1'b0;
    lat = 0;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk); #1;
      if (bus.mem_ready_data1 === 1'b1) begin lat = i; break; end
    end
    checks++; if (lat !== 1) begin failures++; $display("FAIL midreset_reissue_latency got=%0d exp=1", lat); end
    checks++; if (bus.mem_data_rd1 !== 32'h1) begin failures++; $display("FAIL midreset_status got=%h exp=1", bus.mem_data_rd1); end
    @(negedge clk); bus.mem_valid_data1 = 1'b0;
    @(posedge clk); @(posedge clk);
    access(1'b0, DA, 0, rd, lat);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL midreset_rx_flushed got=%h exp=0", rd); end
  endtask

  task automatic test_random;
    logic [31:0] rd, exp;
    logic [27:0] addr;
    logic [7:0] b;
    int lat, op;
    tx_busy = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    m_rx.delete(); tx_exp.delete(); m_ovf = 0; m_drop = 0; m_last = '0;
    tx_seen.delete(); tx_cyc.delete();
    for (int n = 0; n < 120; n++) begin
      op = $urandom_range(0, 9);
      if (op <= 3) begin
        b = 8'($urandom);
        strobe(b);
        if (m_rx.size() < DEPTH) m_rx.push_back(b); else m_ovf = 1;
      end else if (op <= 5) begin
        exp = (m_rx.size() > 0) ? {24'b0, m_rx.pop_front()} : 32'h0;
        access(1'b0, DA, 0, rd, lat);
        m_last = exp;
        checks++; if (rd !== exp || lat !== 1) begin failures++; $display("FAIL rand_data_read[%0d] got=%h lat=%0d exp=%h lat=1", n, rd, lat, exp); end
      end else if (op == 6) begin
        exp = {28'b0, m_drop, m_ovf, m_rx.size() > 0, 1'b1};
        m_ovf = 0; m_drop = 0;
        access(1'b0, SA, 0, rd, lat);
        m_last = exp;
        checks++; if (rd !== exp || lat !== 1) begin failures++; $display("FAIL rand_status[%0d] got=%h lat=%0d exp=%h lat=1", n, rd, lat, exp); end
      end else if (op == 7) begin
        b = 8'($urandom);
        tx_exp.push_back(b);
        access(1'b1, DA, {24'($urandom), b}, rd, lat);
        checks++; if (rd !== m_last || lat !== 1) begin failures++; $display("FAIL rand_tx_write_rd_hold[%0d] got=%h lat=%0d exp=%h lat=1", n, rd, lat, m_last); end
      end else if (op == 8) begin
        addr = 28'h0000100 + 28'($urandom_range(0, 4095));
        access(1'b0, addr, 0, rd, lat);
        m_last = 32'h0;
        checks++; if (rd !== 32'h0 || lat !== 1) begin failures++; $display("FAIL rand_unmapped_read[%0d] got=%h lat=%0d exp=0 lat=1", n, rd, lat); end
      end else begin
        addr = ($urandom_range(0, 1) == 1) ? SA : 28'h0000200 + 28'($urandom_range(0, 4095));
        access(1'b1, addr, $urandom, rd, lat);
        checks++; if (rd !== m_last || lat !== 1) begin failures++; $display("FAIL rand_ignored_write[%0d] got=%h lat=%0d exp=%h lat=1", n, rd, lat, m_last); end
      end
    end
    repeat (20) @(posedge clk);
    checks++; if (tx_seen.size() !== tx_exp.size()) begin failures++; $display("FAIL rand_tx_count got=%0d exp=%0d", tx_seen.size(), tx_exp.size()); end
    for (int i = 0; i < tx_exp.size() && i < tx_seen.size(); i++) begin
      checks++; if (tx_seen[i] !== tx_exp[i]) begin failures++; $display("FAIL rand_tx_byte[%0d] got=%h exp=%h", i, tx_seen[i], tx_exp[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_rx_path();
    test_rx_overflow();
    test_tx_path();
    test_tx_full();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
